// File: rtl/puf_soc_pkg.sv
// Shared definitions for the RO PUF reader: FSM state codes and default sizing.
`timescale 1ns/100ps
package puf_soc_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_COUNT  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int CNT_W_DEF         = 16;
  localparam int WINDOW_CYCLES_DEF = 1024;
  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int SYNC_STAGES_DEF   = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/puf_soc_ro_meas_if.sv
// Request/response and RO signals of the RO PUF reader.
// Count outputs exist only when PUF_SOC_RO_MEAS_CNT_OUT_EN is defined.
`timescale 1ns/100ps
interface puf_soc_ro_meas_if
`ifdef PUF_SOC_RO_MEAS_CNT_OUT_EN
  #(parameter int CNT_W = 16)
`endif
  ;
  // i_start is a level request, sampled only while the reader is idle;
  // o_valid is a one-cycle pulse that qualifies o_resp/o_tie (and o_cnt_*).
  logic       i_start;
  logic       i_ro_a;
  logic       i_ro_b;
  logic [1:0] o_ro_en;
  logic       o_busy;
  logic       o_valid;
  logic       o_resp;
  logic       o_tie;
`ifdef PUF_SOC_RO_MEAS_CNT_OUT_EN
  logic [CNT_W-1:0] o_cnt_a;
  logic [CNT_W-1:0] o_cnt_b;

  modport master (output i_start, i_ro_a, i_ro_b,
                  input  o_ro_en, o_busy, o_valid, o_resp, o_tie, o_cnt_a, o_cnt_b);
  modport slave  (input  i_start, i_ro_a, i_ro_b,
                  output o_ro_en, o_busy, o_valid, o_resp, o_tie, o_cnt_a, o_cnt_b);
`else
  modport master (output i_start, i_ro_a, i_ro_b,
                  input  o_ro_en, o_busy, o_valid, o_resp, o_tie);
  modport slave  (input  i_start, i_ro_a, i_ro_b,
                  output o_ro_en, o_busy, o_valid, o_resp, o_tie);
`endif

endinterface

// File: rtl/puf_soc_ro_edge_cnt.sv
// One RO channel: synchroniser into i_clk, rising-edge detect, saturating edge counter.
`timescale 1ns/100ps
module puf_soc_ro_edge_cnt #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_cnt_en,
    input  logic             i_ro,
    output logic [CNT_W-1:0] o_cnt
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            o_cnt  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_ro};
            prev_q <= sync_q[SYNC_STAGES-1];
            // Edges outside the enable window are seen by prev_q but never counted.
            if (i_clr) begin
                o_cnt <= '0;
            end else if (i_cnt_en && rise && (o_cnt != {CNT_W{1'b1}})) begin
                o_cnt <= o_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/puf_soc_ro_meas.sv
// RO PUF reader: enables an RO pair, counts edges over a fixed window, reports A>B.
// Optional count outputs: define PUF_SOC_RO_MEAS_CNT_OUT_EN.
`timescale 1ns/100ps
module puf_soc_ro_meas
    import puf_soc_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int WINDOW_CYCLES = WINDOW_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF
) (
    input logic i_clk,
    input logic i_rst,
    puf_soc_ro_meas_if.slave bus
);

    localparam int TMR_W = $clog2(max_int(WINDOW_CYCLES, SETTLE_CYCLES) + 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [TMR_W-1:0] timer;
    logic [1:0]       ro_en_q;
    logic             resp_q;
    logic             tie_q;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cmp_gt;
    logic             cmp_eq;
    logic             done;

    assign cnt_clr = (state == ST_IDLE) && bus.i_start;
    assign cnt_en  = (state == ST_COUNT);
    assign done    = (state == ST_DONE);
    assign cmp_gt  = (cnt_a > cnt_b);
    assign cmp_eq  = (cnt_a == cnt_b);

    puf_soc_ro_edge_cnt #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(cnt_clr), .i_cnt_en(cnt_en),
        .i_ro(bus.i_ro_a), .o_cnt(cnt_a)
    );

    puf_soc_ro_edge_cnt #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)) u_cnt_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_clr(cnt_clr), .i_cnt_en(cnt_en),
        .i_ro(bus.i_ro_b), .o_cnt(cnt_b)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.i_start) state_nxt = ST_SETTLE;
            ST_SETTLE: if (timer == TMR_W'(SETTLE_CYCLES - 1)) state_nxt = ST_COUNT;
            ST_COUNT:  if (timer == TMR_W'(WINDOW_CYCLES - 1)) state_nxt = ST_DONE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            timer   <= '0;
            ro_en_q <= 2'b00;
            resp_q  <= 1'b0;
            tie_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            timer   <= ((state_nxt != state) || (state == ST_IDLE)) ? '0 : timer + TMR_W'(1);
            ro_en_q <= ((state_nxt == ST_SETTLE) || (state_nxt == ST_COUNT)) ? 2'b11 : 2'b00;
            if (done) begin
                resp_q <= cmp_gt;
                tie_q  <= cmp_eq;
            end
        end
    end

    // Counters are final and frozen in DONE, so the live compare is shown there and
    // the captured copy holds the answer until the next DONE.
    assign bus.o_ro_en = ro_en_q;
    assign bus.o_busy  = (state != ST_IDLE);
    assign bus.o_valid = done;
    assign bus.o_resp  = done ? cmp_gt : resp_q;
    assign bus.o_tie   = done ? cmp_eq : tie_q;

`ifdef PUF_SOC_RO_MEAS_CNT_OUT_EN
    logic [CNT_W-1:0] cnt_a_q;
    logic [CNT_W-1:0] cnt_b_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else if (done) begin
            cnt_a_q <= cnt_a;
            cnt_b_q <= cnt_b;
        end
    end

    assign bus.o_cnt_a = done ? cnt_a : cnt_a_q;
    assign bus.o_cnt_b = done ? cnt_b : cnt_b_q;
`endif

endmodule
